// File: rtl/axi_lite_arbiter_pkg.sv
// Shared codes for the IFU/LSU AXI4-Lite arbiter: grant encodings, FSM states, AXI resp values.
package axi_lite_arbiter_pkg;
    localparam int NUM_ARB_MASTERS = 2;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_LS = 2'd2,
        ST_WR_LS = 2'd3
    } arb_state_t;
endpackage

// File: rtl/axi_lite_arbiter_arb_picker.sv
// Winner selection for the IDLE state. ARB_ROUND_ROBIN_EN swaps fixed LSU priority for
// alternation on simultaneous requests (i_last: 0 = IFU, 1 = LSU granted most recently).
module arb_picker
    import axi_lite_arbiter_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_m1_arvalid,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       i_last,
`endif
    output arb_state_t o_next
);
    logic w_lsu_wins;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_lsu_wins = i_req1 & (~i_req0 | ~i_last);
`else
    assign w_lsu_wins = i_req1;
`endif

    // An LSU with both AR and AW pending is served read-first
    always_comb begin
        o_next = ST_IDLE;
        if (w_lsu_wins)
            o_next = i_m1_arvalid ? ST_RD_LS : ST_WR_LS;
        else if (i_req0)
            o_next = ST_RD_IF;
    end
endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction
// at a time. Optional macro ARB_ROUND_ROBIN_EN selects alternating priority.
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [1:0]          grant,
    output logic                busy
);
    arb_state_t r_state;
    arb_state_t w_next;
    logic [1:0] r_grant;
    logic       r_ar_done, r_aw_done, r_w_done;
    logic       w_wr_both;
`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last;
`endif

    arb_picker u_picker (
        .i_req0       (m0_arvalid),
        .i_req1       (m1_arvalid | m1_awvalid),
        .i_m1_arvalid (m1_arvalid),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last       (r_last),
`endif
        .o_next       (w_next)
    );

    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign w_wr_both = r_aw_done & r_w_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_grant   <= GRANT_NONE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= w_next;
                    case (w_next)
                        ST_RD_IF:           r_grant <= GRANT_IFU;
                        ST_RD_LS, ST_WR_LS: r_grant <= GRANT_LSU;
                        default:            r_grant <= GRANT_NONE;
                    endcase
`ifdef ARB_ROUND_ROBIN_EN
                    if (w_next != ST_IDLE)
                        r_last <= (w_next != ST_RD_IF);
`endif
                end
                ST_RD_IF, ST_RD_LS: begin
                    if (s_arvalid && s_arready)
                        r_ar_done <= 1'b1;
                    if (s_rvalid && s_rready) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= GRANT_NONE;
                        r_ar_done <= 1'b0;
                    end
                end
                default: begin
                    if (s_awvalid && s_awready)
                        r_aw_done <= 1'b1;
                    if (s_wvalid && s_wready)
                        r_w_done  <= 1'b1;
                    if (s_bvalid && s_bready) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= GRANT_NONE;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Channel routing; everything not owned by the current state stays at zero
    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        case (r_state)
            ST_RD_IF: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid & ~r_ar_done;
                m0_arready = s_arready & ~r_ar_done;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            ST_RD_LS: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid & ~r_ar_done;
                m1_arready = s_arready & ~r_ar_done;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            ST_WR_LS: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid & ~r_aw_done;
                m1_awready = s_awready & ~r_aw_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid & ~r_w_done;
                m1_wready  = s_wready & ~r_w_done;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid & w_wr_both;
                s_bready   = m1_bready & w_wr_both;
            end
            default: ;
        endcase
    end
endmodule
